serial_adder: RTL
=================

# serial_adder

Bit-serial N-bit adder built around the team's single-bit `Full_Adder` cell. It adds two WIDTH-bit operands LSB-first, one bit per clock, through one `Full_Adder` instance with the carry held in a flip-flop. It sits directly upstream of the full adder, sequencing its inputs, and directly downstream of it, collecting its `s` and `cout` outputs. It replaces a WIDTH-wide ripple adder where area matters more than latency.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; must be at least 2.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request a new addition; sampled only in IDLE.
- `a`  input  WIDTH  operand A; captured on the accepted `start` edge.
- `b`  input  WIDTH  operand B; captured on the accepted `start` edge.
- `cin`  input  1  carry-in; captured on the accepted `start` edge.
- `busy`  output  1  high in SHIFT and DONE.
- `done`  output  1  one-cycle pulse; `sum` and `cout` are valid when it is high.
- `sum`  output  WIDTH  registered result of `a+b+cin`, bits [WIDTH-1:0].
- `cout`  output  1  registered carry-out, bit WIDTH of the result.

## Operation
- One `Full_Adder` instance. Its inputs are `a_sr[0]`, `b_sr[0]` and the `carry` flop; its outputs are `s` and `cout`.
- Internal state: `a_sr`, `b_sr` and `s_sr`, each WIDTH bits; `carry`, 1 bit; `cnt`, $clog2(WIDTH) bits; a 2-bit state register.
- FSM states:
  - IDLE:
    - `start`=1 → load `a_sr`=`a`, `b_sr`=`b`, `carry`=`cin`, `cnt`=0; go to SHIFT.
    - `start`=0 → stay in IDLE.
  - SHIFT, every cycle:
    - `a_sr` and `b_sr` shift right by one.
    - `s_sr` = {fa.s, `s_sr`[WIDTH-1:1]}.
    - `carry` = fa.cout.
    - `cnt`++.
    - When `cnt`==WIDTH-1, load `sum` = {fa.s, `s_sr`[WIDTH-1:1]} and `cout` = fa.cout, then go to DONE.
  - DONE: `done`=1 for exactly this one cycle; go to IDLE unconditionally.
- `start` is ignored in SHIFT and DONE. Operands are not re-sampled; `a`, `b` and `cin` may change freely after the accepting edge.
- `sum` and `cout` hold their value from the last completion until the next completion. They never show partial results.
- Arithmetic: {`cout`,`sum`} = `a` + `b` + `cin`, modulo 2^(WIDTH+1). There is no overflow flag.
- Reset, asserted at any time including mid-operation:
  - state=IDLE;
  - all shift registers, `carry` and `cnt` = 0;
  - `sum`=0, `cout`=0, `busy`=0, `done`=0.
  - The aborted operation produces no `done`. After `rst` is released, the next `start` is accepted normally.

## Timing
- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0.
- `start` is accepted on edge E0 while in IDLE. `busy` rises after E0.
- Bit i is computed in the cycle after edge E(i). The final bit is registered on edge E(WIDTH).
- `done` is high for one cycle, between E(WIDTH) and E(WIDTH+1). That is WIDTH cycles after acceptance.
- `busy` falls after E(WIDTH+1). Throughput is one operation every WIDTH+2 cycles.
- If `start` is held high continuously, the next operation is accepted on E(WIDTH+2), the first IDLE cycle after DONE.
- Combinational path: one `Full_Adder` plus the flop setup time. No output depends combinationally on an input.

## Test plan
- Exhaustive WIDTH=2: all 32 combinations of `a`, `b` and `cin`, each waiting for `done` → {`cout`,`sum`} equals `a`+`b`+`cin` every time.
- WIDTH=8 directed cases, each checked when `done` is high:
  - `a`=0xFF, `b`=0x01, `cin`=0 → `sum`=0x00, `cout`=1.
  - `a`=0xA5, `b`=0x5A, `cin`=1 → `sum`=0x00, `cout`=1.
  - `a`=0x3C, `b`=0x0F, `cin`=0 → `sum`=0x4B, `cout`=0.
- Latency check: pulse `start` at E0 → `done`=1 only in the cycle after E8, `busy`=1 from E0 to E9, and `sum`/`cout` unchanged from their old values before E8.
- Ignored start: pulse `start` with new operands at E3 during SHIFT → first result unaffected, no second `done`, FSM returns to IDLE.
- Reset mid-operation: assert `rst` asynchronously between E4 and E5 → `busy`, `done`, `sum` and `cout` go to 0 immediately. No `done` follows. A fresh `start` with `a`=0x01, `b`=0x01, `cin`=0 → `sum`=0x02.
- Back-to-back: hold `start`=1 with 0x10+0x20, then switch the operands to 0x7F+0x01 → first `done` shows 0x30; second operation accepted at E10; second `done` shows 0x80, `cout`=0.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one Full_Adder cell, LSB first, one bit per clock.
// {cout,sum} updates only on completion, so it never shows partial results.

module Full_Adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fa_s;
  logic fa_cout;

  Full_Adder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
        s_sr_d  = {fa_s, s_sr_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + 1'b1;
        // Final bit goes straight into the result register alongside s_sr.
        if (cnt_q == CNT_LAST) begin
          sum_d   = {fa_s, s_sr_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == SHIFT) || (state_q == DONE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule
